// File: rtl/booth_r4_accumulator.sv
// Radix-4 Booth recode-and-accumulate stage fed two multiplier bits per cycle.
// Optional build macro BOOTH_R4_UNSIGNED_EN selects unsigned operands (one extra iteration).
module booth_r4_accumulator #(
  parameter int bits = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [bits-1:0]   mcand,
  input  logic [1:0]        pair_in,
  output logic              busy,
  output logic              done,
  output logic [2*bits-1:0] product
);

`ifdef BOOTH_R4_UNSIGNED_EN
  localparam int MW  = bits + 1;
  localparam int NIT = bits / 2 + 1;
  localparam bit UNS = 1'b1;
`else
  localparam int MW  = bits;
  localparam int NIT = bits / 2;
  localparam bit UNS = 1'b0;
`endif
  localparam int AW = 2 * MW;
  localparam int PW = MW + 2;
  localparam int IW = $clog2(NIT);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       mcand_q, mcand_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                prev_q, prev_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2*bits-1:0]   product_q, product_d;

  logic                last;
  logic [1:0]          pair_eff;
  logic [PW-1:0]       m1, m2, pp;
  logic [AW-1:0]       pp_ext;

  assign last = (idx_q == IW'(NIT - 1));
  // In the unsigned build the final iteration recodes an internal 00 pair
  // so the top multiplier bit is treated as magnitude, not sign.
  assign pair_eff = (UNS && last) ? 2'b00 : pair_in;
  assign m1 = {{2{mcand_q[MW-1]}}, mcand_q};
  assign m2 = m1 << 1;

  always_comb begin
    pp = '0;
    unique case ({pair_eff, prev_q})
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m1;
      default:        pp = '0;
    endcase
  end

  assign pp_ext = {{(AW-PW){pp[PW-1]}}, pp};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = MW'(mcand);
          acc_d   = '0;
          prev_d  = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_q + (pp_ext << {idx_q, 1'b0});
        prev_d = pair_eff[1];
        idx_d  = idx_q + 1'b1;
        if (last) begin
          product_d = acc_d[2*bits-1:0];
          done_d    = 1'b1;
          busy_d    = 1'b0;
          idx_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      prev_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      prev_q    <= prev_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_r4_accumulator.sv
// Directed bench for booth_r4_accumulator; models the upstream >>2 multiplier register.
// Honours BOOTH_R4_UNSIGNED_EN to select the matching expected-value set.
module tb_booth_r4_accumulator;

`ifdef BOOTH_R4_UNSIGNED_EN
  localparam int N = 5;
  localparam logic [15:0] B2B_FIRST = 16'h05EE;  // 6 x 253
`else
  localparam int N = 4;
  localparam logic [15:0] B2B_FIRST = 16'hFFEE;  // 6 x -3
`endif
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mcand;
  logic [1:0]  pair_in;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[NV];
  logic [15:0] prev_prod;

  booth_r4_accumulator #(.bits(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand),
    .pair_in(pair_in), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one operation from IDLE and returns in the cycle where done is high.
  // glitch_k >= 0 re-asserts start (with mcand=9) in that iteration.
  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] exp,
                        input logic [15:0] hold, input int glitch_k);
    logic [7:0] sr;
    start = 1'b1;
    mcand = mc;
    pair_in = 2'b00;
    cycle();
    start = 1'b0;
    mcand = ~mc;
    sr = mp;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 0; k < N; k++) begin
      pair_in = (k < 4) ? sr[1:0] : 2'b11;
      sr = sr >> 2;
      if (k == glitch_k) begin
        start = 1'b1;
        mcand = 8'd9;
      end else begin
        start = 1'b0;
      end
      cycle();
      if (k < N - 1) begin
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("no_early_done", {31'd0, done}, 32'd0);
        chk("product_hold_run", {16'd0, product}, {16'd0, hold});
      end
    end
    start = 1'b0;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    chk("product", {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
`ifdef BOOTH_R4_UNSIGNED_EN
    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd200, 8'd3,   16'h0258};
    vecs[3] = '{8'd0,   8'd85,  16'h0000};
    vecs[4] = '{8'd128, 8'd128, 16'h4000};
    vecs[5] = '{8'd15,  8'd17,  16'h00FF};
    vecs[6] = '{8'd35,  8'd0,   16'h0000};
    vecs[7] = '{8'd1,   8'd128, 16'h0080};
    vecs[8] = '{8'd127, 8'd128, 16'h3F80};
    vecs[9] = '{8'd85,  8'd170, 16'h3872};
`else
    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'h80,  8'h80,  16'h4000};
    vecs[2] = '{8'h7F,  8'h80,  16'hC080};
    vecs[3] = '{8'h00,  8'h55,  16'h0000};
    vecs[4] = '{8'hFF,  8'hFF,  16'h0001};
    vecs[5] = '{8'h55,  8'hAA,  16'hE372};
    vecs[6] = '{8'h80,  8'h7F,  16'hC080};
    vecs[7] = '{8'h01,  8'h80,  16'hFF80};
    vecs[8] = '{8'h23,  8'h00,  16'h0000};
    vecs[9] = '{8'hF9,  8'h0B,  16'hFFB3};
`endif

    reset = 1'b1;
    start = 1'b0;
    mcand = '0;
    pair_in = '0;
    cycle();
    cycle();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    reset = 1'b0;
    cycle();
    prev_prod = 16'h0000;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].mc, vecs[i].mp, vecs[i].exp, prev_prod, -1);
      prev_prod = vecs[i].exp;
      pair_in = 2'b11;
      cycle();
      chk("done_single_cycle", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      pair_in = 2'b10;
      cycle();
      chk("idle_product_hold", {16'd0, product}, {16'd0, prev_prod});
    end

    // start re-asserted at E2 must not disturb the operation in flight
    run_op(8'd3, 8'd5, 16'd15, prev_prod, 1);
    cycle();
    chk("glitch_done_once", {31'd0, done}, 32'd0);
    chk("glitch_stays_idle", {31'd0, busy}, 32'd0);
    prev_prod = 16'd15;

    // back-to-back: second start accepted in the done cycle
    run_op(8'd6, 8'hFD, B2B_FIRST, prev_prod, -1);
    run_op(8'd2, 8'd2, 16'd4, B2B_FIRST, -1);
    cycle();
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    chk("b2b_product_hold", {16'd0, product}, 32'd4);

    // asynchronous reset in the middle of a 7x7 operation
    start = 1'b1;
    mcand = 8'd7;
    cycle();
    start = 1'b0;
    pair_in = 2'b11;
    cycle();
    pair_in = 2'b01;
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_busy", {31'd0, busy}, 32'd0);
    chk("midrun_reset_done", {31'd0, done}, 32'd0);
    chk("midrun_reset_product", {16'd0, product}, 32'd0);
    #1 reset = 1'b0;
    for (int k = 0; k < N + 1; k++) begin
      cycle();
      chk("post_reset_no_done", {31'd0, done}, 32'd0);
      chk("post_reset_idle", {31'd0, busy}, 32'd0);
    end
    run_op(8'd7, 8'd7, 16'd49, 16'd0, -1);
    cycle();
    chk("final_done_low", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
